whirlpool_compress: RTL and testbench



---
 rtl/whirlpool_compress_if.sv | 25 ++
 rtl/whirlpool_compress.sv | 139 +++++++++++++
 tb/tb_whirlpool_compress.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/whirlpool_compress_if.sv
// Bundles the whirlpool_compress start/result bus with the key-schedule handshake.
// master = upstream driver and key schedule; slave = the compression block.
interface whirlpool_compress_if;
    logic         i_start;
    logic [511:0] i_hash;
    logic [511:0] i_block;
    logic         o_kx_init;
    logic [511:0] o_kx_key;
    logic         i_subkey_valid;
    logic [511:0] i_subkey;
    logic         o_busy;
    logic         o_done;
    logic [511:0] o_hash;
    logic [3:0]   o_round;

    modport master (
        output i_start, i_hash, i_block, i_subkey_valid, i_subkey,
        input  o_kx_init, o_kx_key, o_busy, o_done, o_hash, o_round
    );

    modport slave (
        input  i_start, i_hash, i_block, i_subkey_valid, i_subkey,
        output o_kx_init, o_kx_key, o_busy, o_done, o_hash, o_round
    );
endinterface

// File: rtl/whirlpool_compress.sv
// Whirlpool Miyaguchi-Preneel compression: H' = W_H(m) ^ H ^ m, one round per subkey strobe.
// Latency is set by the key schedule (10th strobe edge + 1); no stall path, extra strobes are dropped.
module whirlpool_compress #(
    parameter int ROUNDS = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    whirlpool_compress_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL} state_t;

    // S-box mini-boxes E, E^-1, R and the theta circulant row, nibble/byte 0 at the MSB.
    localparam logic [63:0] E_TAB  = 64'h1B9CD6F3E874A250;
    localparam logic [63:0] EI_TAB = 64'hF0D7BE5A92C13486;
    localparam logic [63:0] R_TAB  = 64'h7CBDE49F638A2510;
    localparam logic [63:0] C_TAB  = 64'h0101040108050209;
    localparam logic [3:0]  LAST   = 4'(ROUNDS);

    function automatic logic [3:0] mini(input logic [63:0] tab, input logic [3:0] x);
        return 4'(tab >> (4 * (15 - int'(x))));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] t);
        logic [3:0] u, l, r;
        u = mini(E_TAB, t[7:4]);
        l = mini(EI_TAB, t[3:0]);
        r = mini(R_TAB, u ^ l);
        return {mini(E_TAB, u ^ r), mini(EI_TAB, l ^ r)};
    endfunction

    // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int b = 0; b < 8; b++) begin
            if (c[b]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // gamma + pi (column j rotated down by j), then theta (row times circulant).
    function automatic logic [511:0] wround(input logic [511:0] a);
        logic [511:0] g, o;
        logic [7:0]   acc;
        g = '0;
        o = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                g[511 - 8*(8*i + j) -: 8] = sbox(a[511 - 8*(8*((i - j) & 7) + j) -: 8]);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                acc = '0;
                for (int k = 0; k < 8; k++)
                    acc = acc ^ gmul(g[511 - 8*(8*i + k) -: 8], C_TAB[63 - 8*((j - k) & 7) -: 8]);
                o[511 - 8*(8*i + j) -: 8] = acc;
            end
        return o;
    endfunction

    state_t       state_q, state_d;
    logic [511:0] h_q, h_d, m_q, m_d, st_q, st_d, hash_q, hash_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         init_q, init_d, busy_q, busy_d, done_q, done_d;
    logic [511:0] round_out;

    assign round_out = wround(st_q);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        m_d     = m_q;
        st_d    = st_q;
        cnt_d   = cnt_q;
        hash_d  = hash_q;
        busy_d  = busy_q;
        init_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    h_d     = bus.i_hash;
                    m_d     = bus.i_block;
                    st_d    = bus.i_hash ^ bus.i_block;
                    cnt_d   = '0;
                    init_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.i_subkey_valid && cnt_q != LAST) begin
                    st_d  = round_out ^ bus.i_subkey;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST - 4'd1) state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                hash_d  = st_q ^ h_q ^ m_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            m_q     <= '0;
            st_q    <= '0;
            cnt_q   <= '0;
            hash_q  <= '0;
            init_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            m_q     <= m_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            hash_q  <= hash_d;
            init_q  <= init_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_kx_init = init_q;
    assign bus.o_kx_key  = h_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.o_hash    = hash_q;
    assign bus.o_round   = cnt_q;
endmodule

// File: tb/tb_whirlpool_compress.sv
// Scoreboard bench for whirlpool_compress with a behavioural Whirlpool reference and key schedule.
module tb_whirlpool_compress;
    logic i_clk = 1'b0;
    logic i_rst;
    whirlpool_compress_if bus();

    whirlpool_compress #(.ROUNDS(10)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

    always #5 i_clk = ~i_clk;

    localparam logic [511:0] KAT_DIGEST = 512'h19FA61D75522A4669B44E39C1D2E1726C530232130D407F89AFEE0964997F7A73E83BE698B288FEBCF88E3E03C4F0757EA8964E59B63D93708B138CC42A66EB3;
    localparam logic [511:0] KAT_BLOCK  = {8'h80, 504'h0};

    int           n_checks = 0;
    int           n_pass   = 0;
    int           done_cnt = 0;
    int           init_cnt = 0;
    logic [511:0] exp_q[$];
    logic [7:0]   sb[256];
    logic [511:0] keys[10];
    logic [511:0] ka[10];

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] ref_sbox(input int t);
        int e[16] = '{1, 11, 9, 12, 13, 6, 15, 3, 14, 8, 7, 4, 10, 2, 5, 0};
        int r[16] = '{7, 12, 11, 13, 14, 4, 9, 15, 6, 3, 8, 10, 2, 5, 1, 0};
        int ei[16];
        int u, l, x;
        for (int i = 0; i < 16; i++) ei[e[i]] = i;
        u = e[t >> 4];
        l = ei[t & 15];
        x = r[u ^ l];
        return 8'((e[u ^ x] << 4) | ei[l ^ x]);
    endfunction

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input int c);
        logic [7:0] p;
        logic [8:0] w;
        p = '0;
        w = {1'b0, a};
        for (int b = 0; b < 4; b++) begin
            if (((c >> b) & 1) == 1) p = p ^ w[7:0];
            w = {w[7:0], 1'b0};
            if (w[8]) w = w ^ 9'h11D;
        end
        return p;
    endfunction

    // Table-style round: out[i][j] = XOR_t S(a[i-t][t]) * c[j-t].
    function automatic logic [511:0] ref_round(input logic [511:0] a);
        int         cc[8] = '{1, 1, 4, 1, 8, 5, 2, 9};
        logic [7:0] ab[64];
        logic [7:0] ob[64];
        logic [511:0] o;
        for (int n = 0; n < 64; n++) ab[n] = a[511 - 8*n -: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                ob[8*i + j] = '0;
                for (int t = 0; t < 8; t++)
                    ob[8*i + j] = ob[8*i + j] ^ ref_mul(sb[ab[8*((i - t) & 7) + t]], cc[(j - t) & 7]);
            end
        for (int n = 0; n < 64; n++) o[511 - 8*n -: 8] = ob[n];
        return o;
    endfunction

    function automatic logic [511:0] rc(input int r);
        logic [511:0] o;
        o = '0;
        for (int j = 0; j < 8; j++) o[511 - 8*j -: 8] = sb[8*(r - 1) + j];
        return o;
    endfunction

    function automatic logic [511:0] expected_hash(input logic [511:0] h, input logic [511:0] m);
        logic [511:0] s;
        s = h ^ m;
        for (int r = 0; r < 10; r++) s = ref_round(s) ^ keys[r];
        return s ^ h ^ m;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_op(input logic [511:0] h, input logic [511:0] m);
        bus.i_start = 1'b1;
        bus.i_hash  = h;
        bus.i_block = m;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic strobe(input logic [511:0] k);
        bus.i_subkey_valid = 1'b1;
        bus.i_subkey       = k;
        tick();
        bus.i_subkey_valid = 1'b0;
    endtask

    // Key-schedule stand-in: one subkey every 2 cycles starting from K0 = h.
    task automatic run_ks(input logic [511:0] h, input int n);
        logic [511:0] k;
        k = h;
        for (int r = 1; r <= n; r++) begin
            tick();
            k = ref_round(k) ^ rc(r);
            strobe(k);
        end
    endtask

    task automatic wait_done(input string tag, input int target);
        for (int i = 0; i < 200 && done_cnt < target; i++) @(negedge i_clk);
        check_val(tag, 512'(done_cnt >= target), 512'(1));
    endtask

    always @(negedge i_clk) begin
        if (bus.o_kx_init) init_cnt++;
        if (bus.o_done) begin
            done_cnt++;
            check_val("busy_low_at_done", 512'(bus.o_busy), 512'(0));
            if (exp_q.size() == 0) check_val("unexpected_done", 512'(bus.o_done), 512'(0));
            else check_val("done_hash", bus.o_hash, exp_q.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [511:0] h, m, h2, hr, exp_a, exp_b;
        int tgt, init0;
        bus.i_start = 1'b0;
        bus.i_hash = '0;
        bus.i_block = '0;
        bus.i_subkey_valid = 1'b0;
        bus.i_subkey = '0;
        i_rst = 1'b1;
        for (int t = 0; t < 256; t++) sb[t] = ref_sbox(t);
        tick();
        tick();
        check_val("rst_hash", bus.o_hash, '0);
        check_val("rst_kx_key", bus.o_kx_key, '0);
        check_val("rst_round", 512'(bus.o_round), '0);
        check_val("rst_busy", 512'(bus.o_busy), '0);
        check_val("rst_done", 512'(bus.o_done), '0);
        check_val("rst_init", 512'(bus.o_kx_init), '0);
        i_rst = 1'b0;
        tick();

        // Known answer: Whirlpool of the empty string.
        init0 = init_cnt;
        tgt = done_cnt + 1;
        exp_q.push_back(KAT_DIGEST);
        start_op('0, KAT_BLOCK);
        check_val("kat_busy", 512'(bus.o_busy), 512'(1));
        check_val("kat_init", 512'(bus.o_kx_init), 512'(1));
        run_ks('0, 10);
        wait_done("kat_done", tgt);
        check_val("kat_init_pulses", 512'(init_cnt - init0), 512'(1));
        tick();
        check_val("kat_done_single", 512'(bus.o_done), 512'(0));

        // Back-to-back strobes.
        h = rand512();
        m = rand512();
        for (int r = 0; r < 10; r++) keys[r] = rand512();
        exp_q.push_back(expected_hash(h, m));
        tgt = done_cnt + 1;
        start_op(h, m);
        for (int r = 0; r < 10; r++) strobe(keys[r]);
        check_val("b2b_done_early", 512'(bus.o_done), 512'(0));
        check_val("b2b_round", 512'(bus.o_round), 512'(10));
        tick();
        check_val("b2b_done_lat", 512'(bus.o_done), 512'(1));
        wait_done("b2b_done", tgt);
        tick();

        // Gapped strobes with ignored strobes in IDLE and after the 10th.
        h = rand512();
        m = rand512();
        for (int r = 0; r < 10; r++) keys[r] = rand512();
        for (int i = 0; i < 3; i++) strobe(rand512());
        check_val("idle_round_hold", 512'(bus.o_round), 512'(10));
        exp_q.push_back(expected_hash(h, m));
        tgt = done_cnt + 1;
        start_op(h, m);
        check_val("start_round", 512'(bus.o_round), '0);
        for (int r = 0; r < 10; r++) begin
            repeat ($urandom_range(0, 5)) tick();
            strobe(keys[r]);
            if (r == 3) check_val("gap_round4", 512'(bus.o_round), 512'(4));
        end
        for (int i = 0; i < 3; i++) strobe(rand512());
        check_val("gap_round_sat", 512'(bus.o_round), 512'(10));
        wait_done("gap_done", tgt);

        // Start pulsed mid-run is ignored.
        h = rand512();
        m = rand512();
        h2 = rand512();
        for (int r = 0; r < 10; r++) keys[r] = rand512();
        exp_q.push_back(expected_hash(h, m));
        tgt = done_cnt + 1;
        start_op(h, m);
        for (int r = 0; r < 3; r++) strobe(keys[r]);
        start_op(h2, rand512());
        check_val("midrun_kx_key", bus.o_kx_key, h);
        check_val("midrun_busy", 512'(bus.o_busy), 512'(1));
        check_val("midrun_round", 512'(bus.o_round), 512'(3));
        for (int r = 3; r < 10; r++) strobe(keys[r]);
        wait_done("midrun_done", tgt);
        tick();

        // Reset after the 4th subkey, then a fresh known-answer run.
        hr = rand512();
        start_op(hr, rand512());
        run_ks(hr, 4);
        check_val("pre_rst_round", 512'(bus.o_round), 512'(4));
        i_rst = 1'b1;
        tick();
        exp_q.delete();
        check_val("mid_rst_hash", bus.o_hash, '0);
        check_val("mid_rst_kx_key", bus.o_kx_key, '0);
        check_val("mid_rst_round", 512'(bus.o_round), '0);
        check_val("mid_rst_busy", 512'(bus.o_busy), '0);
        check_val("mid_rst_done", 512'(bus.o_done), '0);
        check_val("mid_rst_init", 512'(bus.o_kx_init), '0);
        i_rst = 1'b0;
        tick();
        tgt = done_cnt + 1;
        exp_q.push_back(KAT_DIGEST);
        start_op('0, KAT_BLOCK);
        run_ks('0, 10);
        wait_done("kat2_done", tgt);
        tick();

        // Start held high across two operations.
        h = rand512();
        m = rand512();
        for (int r = 0; r < 10; r++) keys[r] = rand512();
        exp_a = expected_hash(h, m);
        for (int r = 0; r < 10; r++) ka[r] = keys[r];
        h2 = rand512();
        hr = rand512();
        for (int r = 0; r < 10; r++) keys[r] = rand512();
        exp_b = expected_hash(h2, hr);
        exp_q.push_back(exp_a);
        tgt = done_cnt + 2;
        bus.i_start = 1'b1;
        bus.i_hash  = h;
        bus.i_block = m;
        tick();
        bus.i_hash  = h2;
        bus.i_block = hr;
        for (int r = 0; r < 10; r++) strobe(ka[r]);
        tick();
        check_val("held_done", 512'(bus.o_done), 512'(1));
        exp_q.push_back(exp_b);
        tick();
        check_val("held_accept_init", 512'(bus.o_kx_init), 512'(1));
        check_val("held_kx_key", bus.o_kx_key, h2);
        check_val("held_busy", 512'(bus.o_busy), 512'(1));
        bus.i_start = 1'b0;
        for (int r = 0; r < 5; r++) strobe(keys[r]);
        check_val("held_hash_hold", bus.o_hash, exp_a);
        for (int r = 5; r < 10; r++) strobe(keys[r]);
        wait_done("held_done2", tgt);
        tick();
        tick();
        check_val("queue_drained", 512'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
